param_state_sequencer: RTL and testbench
========================================

// Module: param_state_sequencer
// PURPOSE
//  Parametrised cyclic state sequencer: walks states 0..NUM_STATES-1 and wraps to 0. Each state has a
//  programmable minimum dwell time. Supports hold, a priority jump, and illegal-state recovery.
//  A visited-state bitmap exposes unreachable states at run time. Sits in control paths as the
//  generic successor of the hand-coded 2-bit toggling FSMs.
// PARAMETERS
//  NUM_STATES     4   number of legal states, >=2; need not be a power of two
//  DWELL_W        8   width of per-state dwell config and dwell counter
//  RECOVER_STATE  0   state forced after an illegal encoding is detected; must be < NUM_STATES
//  (local) STATE_W = $clog2(NUM_STATES)
// PORTS
//  clk            in   1                   clock, rising edge
//  rst            in   1                   reset, asynchronous, active-high
//  adv            in   1                   request advance to next state
//  hold           in   1                   freeze state; dwell counter keeps counting
//  jump_valid     in   1                   jump request, one cycle
//  jump_state     in   STATE_W             jump target
//  dwell_cfg      in   NUM_STATES*DWELL_W  min cycles per state before adv is honoured; slice s = state s
//  cov_clr        in   1                   clear visited bitmap
//  err_clr        in   1                   clear sticky error flags
//  state          out  STATE_W             current state
//  state_entry    out  1                   high in first cycle of any newly entered state
//  wrap           out  1                   high in first cycle of state 0 reached by advance from last state
//  dwell_cnt      out  DWELL_W             cycles spent in current state, saturating
//  visited        out  NUM_STATES          bit s set once state s is entered
//  all_visited    out  1                   &visited, combinational
//  err_illegal    out  1                   sticky: state register held encoding >= NUM_STATES
//  err_bad_jump   out  1                   sticky: jump_valid with jump_state >= NUM_STATES
// BEHAVIOUR
//  - Reset values: state=0, state_entry=1, wrap=0, dwell_cnt=0, visited=1 (bit 0 only), both errors=0.
//  - Next-state priority, evaluated every cycle; the state register updates on the next edge:
//    1. illegal: state >= NUM_STATES -> RECOVER_STATE; err_illegal<=1. All requests this cycle are ignored.
//    2. jump: jump_valid & jump_state<NUM_STATES -> jump_state. Dwell and hold are ignored.
//       A jump to the current state counts as re-entry.
//    3. jump_valid & jump_state>=NUM_STATES -> err_bad_jump<=1; evaluation falls through to 4/5.
//    4. advance: adv & ~hold & (dwell_cnt >= dwell_cfg[state]) -> state+1, or 0 if state==NUM_STATES-1.
//    5. otherwise: stay.
//  - Any transition, including jump-to-self and recovery, produces the following in the first cycle
//    in the new state: dwell_cnt=0, state_entry=1, and visited[new] set.
//  - dwell_cnt increments each cycle with no transition and saturates at 2^DWELL_W-1.
//  - dwell_cfg=0 lets adv be honoured on the entry cycle, giving 1 state per cycle.
//  - wrap is asserted only for a rule-4 advance from NUM_STATES-1. A jump to 0 never asserts wrap.
//  - cov_clr: visited <= one-hot of the state occupied next cycle. A simultaneous entry is therefore kept.
//  - err_clr clears the sticky flags. A new error event in the same cycle wins (flag stays 1).
//  - Decision is combinational from the current inputs: 1-cycle latency from request to state change.
//    No input buffering; a request not honoured in its cycle is dropped.
//  - Reset mid-operation: all registers return to their reset values immediately, asynchronously.
//  - dwell_cfg is sampled every cycle. Changing it mid-dwell takes effect at once against the running count.
// STRUCTURE
//  - Shared package seq_pkg: the STATE_W clog2 helper function, the default RECOVER_STATE constant,
//    and a typedef for the next-state reason (NS_HOLD, NS_ADV, NS_JUMP, NS_RECOVER).
//  - One sub-module: sat_counter #(W) (clr, inc -> cnt) for dwell_cnt.
//  - Visited bitmap, error flags and next-state logic stay in this module.
// TESTING
//  1. NUM_STATES=3, dwell_cfg=0, adv=1 constantly -> state 0,1,2,0,1 on consecutive cycles;
//     wrap=1 on each return to 0; state_entry=1 every cycle.
//  2. dwell_cfg[1]=5, adv=1 -> state 1 lasts exactly 6 cycles (dwell_cnt 0..5) before moving to 2.
//     Then raise hold for 3 cycles at dwell_cnt=5 -> no move until hold drops.
//  3. In state 1 with dwell_cnt=2 < cfg, jump_valid to 2 while hold=1 -> state=2 next cycle,
//     dwell_cnt=0, wrap=0.
//     Repeat with jump_state=3 (NUM_STATES=3) -> err_bad_jump=1 and adv is processed normally.
//  4. Force state=3 with NUM_STATES=3, RECOVER_STATE=1 -> next cycle state=1, err_illegal=1, visited[1]=1.
//     Then assert err_clr and a new forced illegal in the same cycle -> flag stays 1.
//  5. Run 0->1 only via jumps, with state 2 never entered -> visited=3'b011 and all_visited=0.
//     Then cov_clr on the cycle entering 2 -> visited=3'b100.
//  6. Assert rst asynchronously mid-dwell in state 2 -> state=0, dwell_cnt=0, visited=001,
//     and errors clear before the next clock edge.

Source files
------------

// File: rtl/param_state_sequencer_pkg.sv
// Shared definitions for the cyclic state sequencer: state-width helper,
// default recovery target and the next-state reason encoding.
package seq_pkg;

    localparam int DEFAULT_RECOVER_STATE = 0;

    typedef enum logic [1:0] {
        NS_HOLD,
        NS_ADV,
        NS_JUMP,
        NS_RECOVER
    } ns_reason_t;

    // At least one bit, even for degenerate counts, so the state port always exists.
    function automatic int state_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/param_state_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the per-state dwell count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/param_state_sequencer.sv
// Parametrised cyclic state sequencer with per-state minimum dwell, hold,
// priority jump, illegal-state recovery and a visited-state bitmap.
module param_state_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STATES    = 4,
    parameter int DWELL_W       = 8,
    parameter int RECOVER_STATE = DEFAULT_RECOVER_STATE,
    localparam int STATE_W      = state_w(NUM_STATES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          adv,
    input  logic                          hold,
    input  logic                          jump_valid,
    input  logic [STATE_W-1:0]            jump_state,
    input  logic [NUM_STATES*DWELL_W-1:0] dwell_cfg,
    input  logic                          cov_clr,
    input  logic                          err_clr,
    output logic [STATE_W-1:0]            state,
    output logic                          state_entry,
    output logic                          wrap,
    output logic [DWELL_W-1:0]            dwell_cnt,
    output logic [NUM_STATES-1:0]         visited,
    output logic                          all_visited,
    output logic                          err_illegal,
    output logic                          err_bad_jump
);

    localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] RECOVER    = STATE_W'(RECOVER_STATE);

    logic [STATE_W-1:0] state_q;
    // All next-state logic reads this net so the register value has a single observation point.
    wire  [STATE_W-1:0] cur = state_q;

    ns_reason_t           reason;
    logic [STATE_W-1:0]   nxt;
    logic [DWELL_W-1:0]   cfg_sel;
    logic                 illegal;
    logic                 jump_ok;
    logic                 bad_jump_evt;
    logic                 transition;
    logic                 wrap_nxt;
    logic [NUM_STATES-1:0] nxt_onehot;

    always_comb begin
        reason       = NS_HOLD;
        nxt          = cur;
        bad_jump_evt = 1'b0;
        cfg_sel      = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            if (int'(cur) == s) cfg_sel = dwell_cfg[s*DWELL_W +: DWELL_W];
        end
        illegal = (int'(cur) >= NUM_STATES);
        jump_ok = jump_valid && (int'(jump_state) < NUM_STATES);

        if (illegal) begin
            reason = NS_RECOVER;
            nxt    = RECOVER;
        end else if (jump_ok) begin
            reason = NS_JUMP;
            nxt    = jump_state;
        end else begin
            // A rejected jump target is flagged but does not block a normal advance.
            bad_jump_evt = jump_valid;
            if (adv && !hold && (dwell_cnt >= cfg_sel)) begin
                reason = NS_ADV;
                nxt    = (cur == LAST_STATE) ? '0 : cur + STATE_W'(1);
            end
        end
    end

    assign transition  = (reason != NS_HOLD);
    assign wrap_nxt    = (reason == NS_ADV) && (cur == LAST_STATE);
    assign nxt_onehot  = NUM_STATES'(1) << nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= '0;
            state_entry  <= 1'b1;
            wrap         <= 1'b0;
            visited      <= NUM_STATES'(1);
            err_illegal  <= 1'b0;
            err_bad_jump <= 1'b0;
        end else begin
            state_q      <= nxt;
            state_entry  <= transition;
            wrap         <= wrap_nxt;
            if (cov_clr) begin
                visited <= nxt_onehot;
            end else if (transition) begin
                visited <= visited | nxt_onehot;
            end
            err_illegal  <= illegal      || (err_illegal  && !err_clr);
            err_bad_jump <= bad_jump_evt || (err_bad_jump && !err_clr);
        end
    end

    sat_counter #(
        .W (DWELL_W)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (transition),
        .inc (1'b1),
        .cnt (dwell_cnt)
    );

    assign state       = cur;
    assign all_visited = &visited;

endmodule

// File: tb/tb_param_state_sequencer.sv
// Directed self-checking bench for param_state_sequencer with three states
// and recovery to state 1.
module tb_param_state_sequencer;

    localparam int NS  = 3;
    localparam int DW  = 8;
    localparam int SW  = 2;

    logic          clk;
    logic          rst;
    logic          adv;
    logic          hold;
    logic          jump_valid;
    logic [SW-1:0] jump_state;
    logic [NS*DW-1:0] dwell_cfg;
    logic          cov_clr;
    logic          err_clr;
    logic [SW-1:0] state;
    logic          state_entry;
    logic          wrap;
    logic [DW-1:0] dwell_cnt;
    logic [NS-1:0] visited;
    logic          all_visited;
    logic          err_illegal;
    logic          err_bad_jump;

    int checks = 0;
    int errors = 0;

    param_state_sequencer #(
        .NUM_STATES    (NS),
        .DWELL_W       (DW),
        .RECOVER_STATE (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adv          (adv),
        .hold         (hold),
        .jump_valid   (jump_valid),
        .jump_state   (jump_state),
        .dwell_cfg    (dwell_cfg),
        .cov_clr      (cov_clr),
        .err_clr      (err_clr),
        .state        (state),
        .state_entry  (state_entry),
        .wrap         (wrap),
        .dwell_cnt    (dwell_cnt),
        .visited      (visited),
        .all_visited  (all_visited),
        .err_illegal  (err_illegal),
        .err_bad_jump (err_bad_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; adv = 0; hold = 0; jump_valid = 0; jump_state = 0;
        dwell_cfg = '0; cov_clr = 0; err_clr = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({state, state_entry, wrap, dwell_cnt, visited, err_illegal, err_bad_jump}
            !== {2'd0, 1'b1, 1'b0, 8'd0, 3'b001, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: state=%0d entry=%b wrap=%b dwell=%0d visited=%b ill=%b bj=%b, required 0 1 0 0 001 0 0",
                     state, state_entry, wrap, dwell_cnt, visited, err_illegal, err_bad_jump);
        end
    endtask

    task automatic test_free_run();
        logic [SW-1:0] exp_s [5];
        logic          exp_w [5];
        exp_s = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dwell_cfg = '0;
        adv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state !== exp_s[i] || wrap !== exp_w[i] || state_entry !== 1'b1 || dwell_cnt !== 8'd0) begin
                errors++;
                $display("FAIL free_run[%0d]: state=%0d wrap=%b entry=%b dwell=%0d, required %0d %b 1 0",
                         i, state, wrap, state_entry, dwell_cnt, exp_s[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_dwell_hold();
        dwell_cfg = {8'd0, 8'd5, 8'd0};
        adv = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 2'd1 || dwell_cnt !== 8'd0) begin
            errors++;
            $display("FAIL dwell_enter: state=%0d dwell=%0d, required 1 0", state, dwell_cnt);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (state !== 2'd1 || dwell_cnt !== DW'(k) || state_entry !== 1'b0) begin
                errors++;
                $display("FAIL dwell_count[%0d]: state=%0d dwell=%0d entry=%b, required 1 %0d 0",
                         k, state, dwell_cnt, state_entry, k);
            end
        end
        tick();
        checks++;
        if (state !== 2'd2 || dwell_cnt !== 8'd0 || state_entry !== 1'b1) begin
            errors++;
            $display("FAIL dwell_leave: state=%0d dwell=%0d entry=%b, required 2 0 1", state, dwell_cnt, state_entry);
        end
        tick();
        tick();
        for (int k = 1; k <= 5; k++) tick();
        hold = 1'b1;
        for (int k = 6; k <= 8; k++) begin
            tick();
            checks++;
            if (state !== 2'd1 || dwell_cnt !== DW'(k)) begin
                errors++;
                $display("FAIL hold[%0d]: state=%0d dwell=%0d, required 1 %0d", k, state, dwell_cnt, k);
            end
        end
        hold = 1'b0;
        tick();
        checks++;
        if (state !== 2'd2 || dwell_cnt !== 8'd0) begin
            errors++;
            $display("FAIL hold_release: state=%0d dwell=%0d, required 2 0", state, dwell_cnt);
        end
    endtask

    task automatic test_jump();
        tick();
        tick();
        adv = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 2'd1 || dwell_cnt !== 8'd2) begin
            errors++;
            $display("FAIL jump_setup: state=%0d dwell=%0d, required 1 2", state, dwell_cnt);
        end
        hold = 1'b1; jump_valid = 1'b1; jump_state = 2'd2;
        tick();
        checks++;
        if (state !== 2'd2 || dwell_cnt !== 8'd0 || wrap !== 1'b0 || state_entry !== 1'b1 || err_bad_jump !== 1'b0) begin
            errors++;
            $display("FAIL jump_good: state=%0d dwell=%0d wrap=%b entry=%b bj=%b, required 2 0 0 1 0",
                     state, dwell_cnt, wrap, state_entry, err_bad_jump);
        end
        hold = 1'b0; adv = 1'b1; jump_state = 2'd3;
        tick();
        checks++;
        if (state !== 2'd0 || err_bad_jump !== 1'b1 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL jump_bad: state=%0d bj=%b wrap=%b, required 0 1 1", state, err_bad_jump, wrap);
        end
        jump_valid = 1'b0; adv = 1'b0;
        tick();
        checks++;
        if (err_bad_jump !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL bad_jump_sticky: bj=%b state=%0d, required 1 0", err_bad_jump, state);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_bad_jump !== 1'b0) begin
            errors++;
            $display("FAIL bad_jump_clear: bj=%b, required 0", err_bad_jump);
        end
    endtask

    task automatic test_illegal();
        force dut.cur = 2'd3;
        tick();
        release dut.cur;
        #1;
        checks++;
        if (state !== 2'd1 || err_illegal !== 1'b1 || visited[1] !== 1'b1 || dwell_cnt !== 8'd0 || state_entry !== 1'b1) begin
            errors++;
            $display("FAIL recover: state=%0d ill=%b vis1=%b dwell=%0d entry=%b, required 1 1 1 0 1",
                     state, err_illegal, visited[1], dwell_cnt, state_entry);
        end
        err_clr = 1'b1;
        force dut.cur = 2'd3;
        tick();
        release dut.cur;
        #1;
        checks++;
        if (err_illegal !== 1'b1 || state !== 2'd1) begin
            errors++;
            $display("FAIL clr_vs_event: ill=%b state=%0d, required 1 1", err_illegal, state);
        end
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: ill=%b, required 0", err_illegal);
        end
    endtask

    task automatic test_coverage();
        cov_clr = 1'b1;
        tick();
        cov_clr = 1'b0;
        checks++;
        if (visited !== 3'b010 || state !== 2'd1) begin
            errors++;
            $display("FAIL cov_clear: visited=%b state=%0d, required 010 1", visited, state);
        end
        jump_valid = 1'b1; jump_state = 2'd0;
        tick();
        checks++;
        if (state !== 2'd0 || wrap !== 1'b0 || visited !== 3'b011) begin
            errors++;
            $display("FAIL jump_to_zero: state=%0d wrap=%b visited=%b, required 0 0 011", state, wrap, visited);
        end
        tick();
        checks++;
        if (state !== 2'd0 || state_entry !== 1'b1 || dwell_cnt !== 8'd0) begin
            errors++;
            $display("FAIL jump_self: state=%0d entry=%b dwell=%0d, required 0 1 0", state, state_entry, dwell_cnt);
        end
        jump_state = 2'd1;
        tick();
        checks++;
        if (visited !== 3'b011 || all_visited !== 1'b0) begin
            errors++;
            $display("FAIL unreached: visited=%b all=%b, required 011 0", visited, all_visited);
        end
        jump_state = 2'd2; cov_clr = 1'b1;
        tick();
        cov_clr = 1'b0; jump_valid = 1'b0;
        checks++;
        if (visited !== 3'b100 || state !== 2'd2 || all_visited !== 1'b0) begin
            errors++;
            $display("FAIL cov_clr_entry: visited=%b state=%0d all=%b, required 100 2 0", visited, state, all_visited);
        end
        jump_valid = 1'b1; jump_state = 2'd0;
        tick();
        jump_state = 2'd1;
        tick();
        jump_valid = 1'b0;
        checks++;
        if (visited !== 3'b111 || all_visited !== 1'b1) begin
            errors++;
            $display("FAIL all_visited: visited=%b all=%b, required 111 1", visited, all_visited);
        end
    endtask

    task automatic test_async_reset();
        jump_valid = 1'b1; jump_state = 2'd2;
        tick();
        jump_state = 2'd3;
        tick();
        jump_valid = 1'b0;
        tick();
        checks++;
        if (state !== 2'd2 || dwell_cnt !== 8'd2 || err_bad_jump !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: state=%0d dwell=%0d bj=%b, required 2 2 1", state, dwell_cnt, err_bad_jump);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || dwell_cnt !== 8'd0 || visited !== 3'b001 ||
            err_bad_jump !== 1'b0 || err_illegal !== 1'b0 || state_entry !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: state=%0d dwell=%0d visited=%b bj=%b ill=%b entry=%b, required 0 0 001 0 0 1",
                     state, dwell_cnt, visited, err_bad_jump, err_illegal, state_entry);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_dwell_hold();
        test_jump();
        test_illegal();
        test_coverage();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
